// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth radix-2) and divide (restoring) unit.
// Hi/Lo are only updated on a completed operation; working state is kept separately.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MultStart,
    input  logic             DivStart,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic             q1_r;
    logic [WIDTH:0]   mcand_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic             sign_a_r;
    logic             sign_b_r;

    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   acc_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             q1_next_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_next_s;
    logic             last_iter_s;

    // Two's complement negation modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_val(x) : x;
    endfunction

    // Booth step: conditional add/subtract, then arithmetic shift of {acc,Q,q_1}.
    always_comb begin
        booth_sum_s = acc_r;
        case ({q_r[0], q1_r})
            2'b01:   booth_sum_s = acc_r + mcand_r;
            2'b10:   booth_sum_s = acc_r - mcand_r;
            default: booth_sum_s = acc_r;
        endcase
        acc_next_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
        q_next_s   = {booth_sum_s[0], q_r[WIDTH-1:1]};
        q1_next_s  = q_r[0];
    end

    // Restoring divide step; the extra adder bit carries the borrow.
    always_comb begin
        div_shift_s = {rem_r, dvd_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, dvs_r};
        if (div_trial_s[WIDTH] == 1'b0) begin
            rem_next_s = div_trial_s[WIDTH-1:0];
            dvd_next_s = {dvd_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = div_shift_s[WIDTH-1:0];
            dvd_next_s = {dvd_r[WIDTH-2:0], 1'b0};
        end
        last_iter_s = (count_r == CNT_LAST);
    end

    // Control FSM with registered results and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= {CW{1'b0}};
            acc_r    <= {(WIDTH+1){1'b0}};
            q_r      <= {WIDTH{1'b0}};
            q1_r     <= 1'b0;
            mcand_r  <= {(WIDTH+1){1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            Hi       <= {WIDTH{1'b0}};
            Lo       <= {WIDTH{1'b0}};
            Busy     <= 1'b0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (MultStart) begin
                        acc_r   <= {(WIDTH+1){1'b0}};
                        q_r     <= A;
                        q1_r    <= 1'b0;
                        mcand_r <= {B[WIDTH-1], B};
                        count_r <= {CW{1'b0}};
                        Busy    <= 1'b1;
                        state_r <= MULT;
                    end else if (DivStart) begin
                        if (B == {WIDTH{1'b0}}) begin
                            DivZero <= 1'b1;
                        end else begin
                            rem_r    <= {WIDTH{1'b0}};
                            dvd_r    <= abs_val(A);
                            dvs_r    <= abs_val(B);
                            sign_a_r <= A[WIDTH-1];
                            sign_b_r <= B[WIDTH-1];
                            count_r  <= {CW{1'b0}};
                            Busy     <= 1'b1;
                            state_r  <= DIV;
                        end
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                MULT: begin
                    acc_r   <= acc_next_s;
                    q_r     <= q_next_s;
                    q1_r    <= q1_next_s;
                    count_r <= count_r + CNT_ONE;
                    if (last_iter_s) begin
                        // Low WIDTH bits of the extended accumulator form the upper product half.
                        Hi      <= acc_next_s[WIDTH-1:0];
                        Lo      <= q_next_s;
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= MULT;
                    end
                end
                DIV: begin
                    rem_r   <= rem_next_s;
                    dvd_r   <= dvd_next_s;
                    count_r <= count_r + CNT_ONE;
                    if (last_iter_s) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= DIV;
                    end
                end
                FIX: begin
                    Lo      <= (sign_a_r ^ sign_b_r) ? neg_val(dvd_r) : dvd_r;
                    Hi      <= sign_a_r ? neg_val(rem_r) : rem_r;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
